frog_move_ctrl: RTL and testbench
=================================

// Module: frog_move_ctrl
// PURPOSE
//   Upstream player-input stage for the frog sprite. Synchronises and debounces the four
//   direction buttons and turns each clean press into one grid-step hop. Clamps (or wraps)
//   the frog at the screen edges. Hands each hop to the box draw/erase control FSM via a
//   req/ack handshake, supplying the old position (to erase) and the new position (to draw).
// PARAMETERS
//   DEBOUNCE_CYCLES  250000  stable-level cycles required to accept a button change (5 ms @ 50 MHz)
//   STEP             4       pixels per hop (matches 4x4 sprite)
//   X_MAX            156     largest legal x (left edge of sprite), 160x120 screen
//   Y_MAX            116     largest legal y (top edge of sprite)
//   X_START          76      x after reset
//   Y_START          116     y after reset (bottom row)
// PORTS
//   clock       in   1  system clock (CLOCK_50)
//   resetn      in   1  asynchronous, active-low reset
//   key_up_n    in   1  raw button, active-low, asynchronous to clock
//   key_down_n  in   1  raw button, active-low
//   key_left_n  in   1  raw button, active-low
//   key_right_n in   1  raw button, active-low
//   move_ack    in   1  one-cycle pulse from draw FSM: erase+redraw of this hop complete
//   move_req    out  1  hop pending; old_* and x_pos/y_pos stable while high
//   x_pos       out  8  current/new frog x
//   y_pos       out  7  current/new frog y
//   old_x       out  8  frog x before the pending hop
//   old_y       out  7  frog y before the pending hop
//   hop_count   out  8  completed hops, saturates at 255
// BEHAVIOUR
//   Reset (async): move_req=0, x_pos=old_x=X_START, y_pos=old_y=Y_START, hop_count=0,
//     state=IDLE, synchronisers and debounced levels = 1 (released), debounce counters=0.
//   Input path per key:
//     - 2-flop synchroniser.
//     - Debounce: counter resets whenever the synced level equals the debounced level.
//       Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1 the debounced level flips.
//       Net: a change must be stable DEBOUNCE_CYCLES cycles.
//     - press = debounced 1->0 transition (single-cycle pulse).
//   FSM states: IDLE, REQ, WAIT_REL.
//     IDLE: on any press pulse pick one direction, priority up>down>left>right.
//       - up: y-STEP; down: y+STEP; left: x-STEP; right: x+STEP.
//       - Blocked move (up with y<STEP, down with y+STEP>Y_MAX, left with x<STEP,
//         right with x+STEP>X_MAX): positions unchanged, no request, go to WAIT_REL.
//       - Legal move, same edge: old_x/old_y<=x_pos/y_pos; x_pos/y_pos<=new value;
//         move_req<=1; go to REQ.
//     REQ: hold all position outputs.
//       - On move_ack: move_req<=0 next edge; hop_count+1 (saturating); go to WAIT_REL.
//       - Press pulses during REQ are discarded.
//     WAIT_REL: wait until all four debounced levels are released (1), then go to IDLE.
//       Holding a key never auto-repeats.
//   move_ack outside REQ is ignored. Latency: press pulse -> move_req high = 1 cycle.
//   Arithmetic: x 8-bit, y 7-bit unsigned. Bound checks use 9-/8-bit sums so no overflow
//     aliasing. Positions stay multiples of STEP offset from start.
//   Reset asserted mid-REQ: req drops immediately and positions return to start. The draw FSM
//     is reset by the same resetn.
// CONFIGURATION
//   FROG_WRAP_X_EN defined:
//     - left at x<STEP moves to X_MAX; right at x+STEP>X_MAX moves to 0.
//     - Both are legal hops with move_req.
//     - Vertical edges still clamp.
//   FROG_WRAP_X_EN undefined: horizontal edges clamp as above (blocked, no request).
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//   1. Reset; press up 10 cycles, release.
//      -> one move_req, old_y=116, y_pos=112, x_pos=76. Ack -> req low, hop_count=1.
//   2. Up pulse low 2 cycles (bounce).
//      -> no debounced press, move_req stays 0, positions unchanged.
//   3. Up and right pressed same cycle.
//      -> only up hop (y 116->112, x 76). No second req until both released and pressed again.
//   4. Press down at y=116.
//      -> blocked, move_req never rises, hop_count unchanged.
//   5. Drive x to 0, press left.
//      -> without macro: blocked. With FROG_WRAP_X_EN: req with old_x=0, x_pos=156.
//   6. Assert resetn low while move_req=1.
//      -> move_req=0 and x_pos=76, y_pos=116 with no clock edge. hop_count=0.

Source files
------------

// File: rtl/frog_move_ctrl.sv
// Frog player-input stage: button sync/debounce, edge-clamped grid hops, req/ack hand-off to the draw FSM.
// Optional horizontal wrap-around at the screen edges is enabled by defining FROG_WRAP_X_EN.
module frog_move_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int STEP            = 4,
    parameter int X_MAX           = 156,
    parameter int Y_MAX           = 116,
    parameter int X_START         = 76,
    parameter int Y_START         = 116
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       key_up_n,
    input  logic       key_down_n,
    input  logic       key_left_n,
    input  logic       key_right_n,
    input  logic       move_ack,
    output logic       move_req,
    output logic [7:0] x_pos,
    output logic [6:0] y_pos,
    output logic [7:0] old_x,
    output logic [6:0] old_y,
    output logic [7:0] hop_count
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] STEP_X8  = 8'(STEP);
    localparam logic [8:0] STEP_X9  = 9'(STEP);
    localparam logic [8:0] X_MAX9   = 9'(X_MAX);
    localparam logic [6:0] STEP_Y7  = 7'(STEP);
    localparam logic [7:0] STEP_Y8  = 8'(STEP);
    localparam logic [7:0] Y_MAX8   = 8'(Y_MAX);
    localparam logic [7:0] X_START8 = 8'(X_START);
    localparam logic [6:0] Y_START7 = 7'(Y_START);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    state_t           state_r;
    logic [3:0]       keys_raw_s;
    logic [3:0]       sync1_r;
    logic [3:0]       sync2_r;
    logic [3:0]       level_r;
    logic [3:0]       level_prev_r;
    logic [CNT_W-1:0] cnt_r [4];
    logic [3:0]       press_s;
    logic             blocked_s;
    logic [7:0]       next_x_s;
    logic [6:0]       next_y_s;

    // Bit order: 0 up, 1 down, 2 left, 3 right (index order is also hop priority).
    assign keys_raw_s = {key_right_n, key_left_n, key_down_n, key_up_n};
    assign press_s    = level_prev_r & ~level_r;

    // Two-flop synchroniser for the asynchronous buttons.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_r <= 4'b1111;
            sync2_r <= 4'b1111;
        end else begin
            sync1_r <= keys_raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: a level change must persist DEBOUNCE_CYCLES cycles before it is accepted.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            level_r      <= 4'b1111;
            level_prev_r <= 4'b1111;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            level_prev_r <= level_r;
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] == level_r[i]) begin
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else if (cnt_r[i] == CNT_LAST) begin
                    cnt_r[i]   <= {CNT_W{1'b0}};
                    level_r[i] <= sync2_r[i];
                end else begin
                    cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Target position for the highest-priority press; sums are widened so edge checks cannot alias.
    always_comb begin
        blocked_s = 1'b0;
        next_x_s  = x_pos;
        next_y_s  = y_pos;
        if (press_s[0]) begin
            if ({1'b0, y_pos} < STEP_Y8) begin
                blocked_s = 1'b1;
            end else begin
                next_y_s = y_pos - STEP_Y7;
            end
        end else if (press_s[1]) begin
            if (({1'b0, y_pos} + STEP_Y8) > Y_MAX8) begin
                blocked_s = 1'b1;
            end else begin
                next_y_s = y_pos + STEP_Y7;
            end
        end else if (press_s[2]) begin
            if ({1'b0, x_pos} < STEP_X9) begin
`ifdef FROG_WRAP_X_EN
                next_x_s = X_MAX9[7:0];
`else
                blocked_s = 1'b1;
`endif
            end else begin
                next_x_s = x_pos - STEP_X8;
            end
        end else if (press_s[3]) begin
            if (({1'b0, x_pos} + STEP_X9) > X_MAX9) begin
`ifdef FROG_WRAP_X_EN
                next_x_s = 8'd0;
`else
                blocked_s = 1'b1;
`endif
            end else begin
                next_x_s = x_pos + STEP_X8;
            end
        end else begin
            blocked_s = 1'b0;
        end
    end

    // Hop FSM: one request per clean press, no auto-repeat until every key is released.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r   <= IDLE;
            move_req  <= 1'b0;
            x_pos     <= X_START8;
            y_pos     <= Y_START7;
            old_x     <= X_START8;
            old_y     <= Y_START7;
            hop_count <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|press_s) begin
                        if (blocked_s) begin
                            state_r <= WAIT_REL;
                        end else begin
                            old_x    <= x_pos;
                            old_y    <= y_pos;
                            x_pos    <= next_x_s;
                            y_pos    <= next_y_s;
                            move_req <= 1'b1;
                            state_r  <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (move_ack) begin
                        move_req <= 1'b0;
                        if (hop_count != 8'd255) begin
                            hop_count <= hop_count + 8'd1;
                        end
                        state_r <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (&level_r) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    move_req <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frog_move_ctrl.sv
// Directed bench for frog_move_ctrl with a short debounce window; vector table plus hand-written reset/edge sequences.
module tb_frog_move_ctrl;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       key_up_n = 1'b1;
    logic       key_down_n = 1'b1;
    logic       key_left_n = 1'b1;
    logic       key_right_n = 1'b1;
    logic       move_ack = 1'b0;
    logic       move_req;
    logic [7:0] x_pos;
    logic [6:0] y_pos;
    logic [7:0] old_x;
    logic [6:0] old_y;
    logic [7:0] hop_count;

    int n_chk  = 0;
    int n_fail = 0;

    frog_move_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .key_up_n    (key_up_n),
        .key_down_n  (key_down_n),
        .key_left_n  (key_left_n),
        .key_right_n (key_right_n),
        .move_ack    (move_ack),
        .move_req    (move_req),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .old_x       (old_x),
        .old_y       (old_y),
        .hop_count   (hop_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] keys_n;   // {right, left, down, up}
        logic       ack;
        int         cyc;
        logic       req;
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] ox;
        logic [6:0] oy;
        logic [7:0] hop;
    } vec_t;

    vec_t tab [16];

    function automatic vec_t mk(input logic [3:0] k, input logic a, input int c, input logic r,
                                input int x, input int y, input int ox, input int oy, input int h);
        vec_t v;
        v.keys_n = k;   v.ack = a;        v.cyc = c;   v.req = r;
        v.x  = 8'(x);   v.y  = 7'(y);     v.ox = 8'(ox);
        v.oy = 7'(oy);  v.hop = 8'(h);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_keys(input logic [3:0] k);
        {key_right_n, key_left_n, key_down_n, key_up_n} = k;
    endtask

    task automatic run_vec(input int i);
        set_keys(tab[i].keys_n);
        move_ack = tab[i].ack;
        repeat (tab[i].cyc) @(posedge clock);
        #1;
        move_ack = 1'b0;
        chk($sformatf("v%0d_req", i),   32'(move_req),  32'(tab[i].req));
        chk($sformatf("v%0d_x", i),     32'(x_pos),     32'(tab[i].x));
        chk($sformatf("v%0d_y", i),     32'(y_pos),     32'(tab[i].y));
        chk($sformatf("v%0d_old_x", i), 32'(old_x),     32'(tab[i].ox));
        chk($sformatf("v%0d_old_y", i), 32'(old_y),     32'(tab[i].oy));
        chk($sformatf("v%0d_hop", i),   32'(hop_count), 32'(tab[i].hop));
    endtask

    task automatic wait_req(input int budget);
        int t = 0;
        while (move_req !== 1'b1 && t < budget) begin
            @(posedge clock);
            #1;
            t++;
        end
    endtask

    task automatic do_hop(input logic [3:0] k, input int ex, input int ey, input int eox,
                          input int eoy, input int ehop);
        set_keys(k);
        wait_req(20);
        chk("hop_req_rise", 32'(move_req), 32'd1);
        chk("hop_x",     32'(x_pos), 32'(ex));
        chk("hop_y",     32'(y_pos), 32'(ey));
        chk("hop_old_x", 32'(old_x), 32'(eox));
        chk("hop_old_y", 32'(old_y), 32'(eoy));
        move_ack = 1'b1;
        @(posedge clock);
        #1;
        move_ack = 1'b0;
        chk("hop_req_fall", 32'(move_req),  32'd0);
        chk("hop_count",    32'(hop_count), 32'(ehop));
        set_keys(4'b1111);
        repeat (10) @(posedge clock);
        #1;
    endtask

    initial begin
        tab[0]  = mk(4'b1111, 1'b0, 3,  1'b0, 76, 116, 76, 116, 0);  // reset state
        tab[1]  = mk(4'b1110, 1'b0, 6,  1'b0, 76, 116, 76, 116, 0);  // up: debounced, req not yet
        tab[2]  = mk(4'b1110, 1'b0, 1,  1'b1, 76, 112, 76, 116, 0);  // req one cycle after press
        tab[3]  = mk(4'b1110, 1'b0, 5,  1'b1, 76, 112, 76, 116, 0);  // held, waiting for ack
        tab[4]  = mk(4'b0111, 1'b0, 8,  1'b1, 76, 112, 76, 116, 0);  // right press during REQ discarded
        tab[5]  = mk(4'b0111, 1'b1, 1,  1'b0, 76, 112, 76, 116, 1);  // ack
        tab[6]  = mk(4'b1111, 1'b0, 8,  1'b0, 76, 112, 76, 116, 1);
        tab[7]  = mk(4'b1110, 1'b0, 2,  1'b0, 76, 112, 76, 116, 1);  // 2-cycle bounce
        tab[8]  = mk(4'b1111, 1'b0, 10, 1'b0, 76, 112, 76, 116, 1);
        tab[9]  = mk(4'b0110, 1'b0, 7,  1'b1, 76, 108, 76, 112, 1);  // up+right together: up wins
        tab[10] = mk(4'b0110, 1'b1, 1,  1'b0, 76, 108, 76, 112, 2);
        tab[11] = mk(4'b1110, 1'b0, 10, 1'b0, 76, 108, 76, 112, 2);  // up still held: no repeat
        tab[12] = mk(4'b1111, 1'b0, 10, 1'b0, 76, 108, 76, 112, 2);
        tab[13] = mk(4'b1101, 1'b0, 7,  1'b0, 76, 116, 76, 116, 0);  // down at bottom: blocked
        tab[14] = mk(4'b1101, 1'b0, 5,  1'b0, 76, 116, 76, 116, 0);
        tab[15] = mk(4'b1111, 1'b0, 8,  1'b0, 76, 116, 76, 116, 0);

        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;

        for (int i = 0; i <= 12; i++) begin
            run_vec(i);
        end

        // Reset asserted while a hop is pending: outputs must return without a clock edge.
        set_keys(4'b1101);
        wait_req(20);
        chk("rst_pre_req",   32'(move_req), 32'd1);
        chk("rst_pre_y",     32'(y_pos),    32'd112);
        chk("rst_pre_old_y", 32'(old_y),    32'd108);
        resetn = 1'b0;
        #1;
        chk("rst_req",   32'(move_req),  32'd0);
        chk("rst_x",     32'(x_pos),     32'd76);
        chk("rst_y",     32'(y_pos),     32'd116);
        chk("rst_old_x", 32'(old_x),     32'd76);
        chk("rst_old_y", 32'(old_y),     32'd116);
        chk("rst_hop",   32'(hop_count), 32'd0);
        set_keys(4'b1111);
        repeat (3) @(posedge clock);
        #1;
        resetn = 1'b1;

        for (int i = 13; i <= 15; i++) begin
            run_vec(i);
        end

        // Walk left from 76 to the left edge.
        for (int i = 0; i < 19; i++) begin
            do_hop(4'b1011, 76 - 4 * (i + 1), 116, 76 - 4 * i, 116, i + 1);
        end

        set_keys(4'b1011);
        wait_req(20);
`ifdef FROG_WRAP_X_EN
        chk("edge_left_req",   32'(move_req), 32'd1);
        chk("edge_left_x",     32'(x_pos),    32'd156);
        chk("edge_left_old_x", 32'(old_x),    32'd0);
        move_ack = 1'b1;
        @(posedge clock);
        #1;
        move_ack = 1'b0;
        chk("edge_left_hop", 32'(hop_count), 32'd20);
`else
        chk("edge_left_req",   32'(move_req),  32'd0);
        chk("edge_left_x",     32'(x_pos),     32'd0);
        chk("edge_left_old_x", 32'(old_x),     32'd4);
        chk("edge_left_hop",   32'(hop_count), 32'd19);
`endif
        set_keys(4'b1111);
        repeat (10) @(posedge clock);
        #1;
        chk("final_req", 32'(move_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
